// File: rtl/timer_bank_pkg.sv
// Shared constants for apb_timer_bank: register offsets, CTRL bit positions,
// channel stride and the per-channel state type.
package timer_bank_pkg;

  localparam int unsigned CH_STRIDE = 16;

  localparam logic [3:0] OFF_LOAD   = 4'h0;
  localparam logic [3:0] OFF_CURVAL = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;
  localparam logic [3:0] OFF_EOI    = 4'hC;

  localparam logic [7:0] ADDR_INTSTAT    = 8'hF0;
  localparam logic [7:0] ADDR_EOI_ALL    = 8'hF4;
  localparam logic [7:0] ADDR_RAWINTSTAT = 8'hF8;
  localparam logic [7:0] ADDR_PRESCALE   = 8'hFC;

  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_MODE  = 1;
  localparam int unsigned CTRL_IMASK = 2;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_t;

endpackage

// File: rtl/timer_bank_ch.sv
// One timer channel: LOAD/CTRL registers, down-counter with IDLE/RUN FSM,
// raw interrupt flag and ETB trigger enable/pulse.
module timer_bank_ch
  import timer_bank_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load_we,
  input  logic             ctrl_we,
  input  logic [CNT_W-1:0] wdata,
  input  logic             eoi_clr,
  input  logic             trig_en_on,
  input  logic             trig_en_off,
  output logic [CNT_W-1:0] load,
  output logic [CNT_W-1:0] curval,
  output logic [2:0]       ctrl,
  output logic             raw,
  output logic             imask,
  output logic             trig
);

  ch_state_t        state_q, state_d;
  logic [CNT_W-1:0] load_q, cur_q, cur_d;
  logic             mode_q, imask_q, raw_q, trig_en_q, trig_q;
  logic             expire;

  // CTRL.EN is the FSM state itself; an EN=0 write takes priority over a tick.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    expire  = 1'b0;
    unique case (state_q)
      CH_IDLE: begin
        if (ctrl_we && wdata[CTRL_EN]) begin
          state_d = CH_RUN;
          cur_d   = load_q;
        end
      end
      CH_RUN: begin
        if (ctrl_we && !wdata[CTRL_EN]) begin
          state_d = CH_IDLE;
        end else if (tick) begin
          if (cur_q == '0) begin
            expire = 1'b1;
            if (mode_q) cur_d = load_q;
            else        state_d = CH_IDLE;
          end else begin
            cur_d = cur_q - 1'b1;
          end
        end
      end
      default: state_d = CH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CH_IDLE;
      cur_q     <= '0;
      load_q    <= '0;
      mode_q    <= 1'b0;
      imask_q   <= 1'b0;
      raw_q     <= 1'b0;
      trig_en_q <= 1'b0;
      trig_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      if (load_we) load_q <= wdata;
      if (ctrl_we) begin
        mode_q  <= wdata[CTRL_MODE];
        imask_q <= wdata[CTRL_IMASK];
      end
      // Expiry beats a concurrent EOI clear; trigger-off beats trigger-on.
      if (expire)       raw_q <= 1'b1;
      else if (eoi_clr) raw_q <= 1'b0;
      if (trig_en_off)     trig_en_q <= 1'b0;
      else if (trig_en_on) trig_en_q <= 1'b1;
      trig_q <= expire && trig_en_q;
    end
  end

  assign load   = load_q;
  assign curval = cur_q;
  assign ctrl   = {imask_q, mode_q, state_q == CH_RUN};
  assign raw    = raw_q;
  assign imask  = imask_q;
  assign trig   = trig_q;

endmodule

// File: rtl/apb_timer_bank.sv
// APB multi-channel down-counter timer bank: decode, read mux, shared prescaler.
// Optional shared prescaler enabled by defining TIMER_BANK_PRESCALE_EN.
module apb_timer_bank
  import timer_bank_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  input  logic [NUM_CH-1:0] etb_trig_en_on,
  input  logic [NUM_CH-1:0] etb_trig_en_off,
  output logic [NUM_CH-1:0] intr,
  output logic [NUM_CH-1:0] etb_trig
);

  logic [31:0]       addr;
  logic [3:0]        reg_off;
  logic              in_page, glob_hit, wr_acc, rd_acc, eoi_all;
  logic              tick;
  logic [NUM_CH-1:0] raw, imask;
  logic [31:0]       rd_chain [NUM_CH+1];

  assign addr     = 32'(paddr);
  assign reg_off  = addr[3:0];
  assign in_page  = (addr[31:8] == '0) && (addr[1:0] == 2'b00);
  assign glob_hit = in_page && (addr[7:4] == 4'hF);
  assign wr_acc   = psel && penable && pwrite;
  assign rd_acc   = psel && penable && !pwrite;
  assign eoi_all  = glob_hit && (addr[7:0] == ADDR_EOI_ALL);
  assign intr     = raw & ~imask;
  assign rd_chain[0] = '0;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic             sel;
    logic [CNT_W-1:0] ch_load, ch_cur;
    logic [2:0]       ch_ctrl;
    logic [31:0]      rd;

    assign sel = in_page && ((addr[7:0] & 8'hF0) == 8'(n * CH_STRIDE));

    timer_bank_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk        (pclk),
      .rst        (preset),
      .tick       (tick),
      .load_we    (wr_acc && sel && (reg_off == OFF_LOAD)),
      .ctrl_we    (wr_acc && sel && (reg_off == OFF_CTRL)),
      .wdata      (pwdata[CNT_W-1:0]),
      .eoi_clr    (rd_acc && ((sel && (reg_off == OFF_EOI)) || eoi_all)),
      .trig_en_on (etb_trig_en_on[n]),
      .trig_en_off(etb_trig_en_off[n]),
      .load       (ch_load),
      .curval     (ch_cur),
      .ctrl       (ch_ctrl),
      .raw        (raw[n]),
      .imask      (imask[n]),
      .trig       (etb_trig[n])
    );

    always_comb begin
      rd = '0;
      if (sel) begin
        case (reg_off)
          OFF_LOAD:   rd = 32'(ch_load);
          OFF_CURVAL: rd = 32'(ch_cur);
          OFF_CTRL:   rd = 32'(ch_ctrl);
          OFF_EOI:    rd = 32'(raw[n]);
          default:    rd = '0;
        endcase
      end
    end

    // Channel pages never overlap, so the read mux reduces to an OR chain.
    assign rd_chain[n+1] = rd_chain[n] | rd;
  end

`ifdef TIMER_BANK_PRESCALE_EN
  logic [7:0] prescale_q, pcnt_q;

  assign tick = (pcnt_q == prescale_q);

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      prescale_q <= '0;
      pcnt_q     <= '0;
    end else if (wr_acc && glob_hit && (addr[7:0] == ADDR_PRESCALE)) begin
      prescale_q <= pwdata[7:0];
      pcnt_q     <= '0;
    end else if (tick) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + 1'b1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    prdata = '0;
    if (psel && !pwrite) begin
      prdata = rd_chain[NUM_CH];
      if (glob_hit) begin
        case (addr[7:0])
          ADDR_INTSTAT:    prdata = 32'(intr);
          ADDR_EOI_ALL:    prdata = 32'(intr);
          ADDR_RAWINTSTAT: prdata = 32'(raw);
`ifdef TIMER_BANK_PRESCALE_EN
          ADDR_PRESCALE:   prdata = 32'(prescale_q);
`endif
          default:         prdata = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apb_timer_bank.sv
// Self-checking bench for apb_timer_bank: spec-level model compared every cycle
// plus directed scenarios with literal expectations (covers TIMER_BANK_PRESCALE_EN when defined).
module tb_apb_timer_bank;

  localparam int NCH = 2;

  logic        pclk = 1'b0;
  logic        preset, psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata, prdata16;
  logic [1:0]  etb_on, etb_off, intr, etb_trig;
  logic [0:0]  intr16, etb16;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  apb_timer_bank #(.NUM_CH(2), .CNT_W(32), .ADDR_W(8)) dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .etb_trig_en_on(etb_on), .etb_trig_en_off(etb_off),
    .intr(intr), .etb_trig(etb_trig)
  );

  apb_timer_bank #(.NUM_CH(1), .CNT_W(16), .ADDR_W(8)) dut16 (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata16),
    .etb_trig_en_on(etb_on[0:0]), .etb_trig_en_off(etb_off[0:0]),
    .intr(intr16), .etb_trig(etb16)
  );

  // Behavioural model of the 2-channel, 32-bit instance
  logic [31:0] m_load [NCH];
  logic [31:0] m_cur  [NCH];
  logic        m_en   [NCH];
  logic        m_mode [NCH];
  logic        m_mask [NCH];
  logic        m_raw  [NCH];
  logic        m_ten  [NCH];
  logic        m_trig [NCH];
  logic [7:0]  m_ps, m_pcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] a);
    logic [31:0] r;
    logic [31:0] ints, raws;
    r = '0;
    ints = '0;
    raws = '0;
    for (int n = 0; n < NCH; n++) begin
      raws[n] = m_raw[n];
      ints[n] = m_raw[n] & ~m_mask[n];
    end
    if (a[1:0] != 2'b00) return '0;
    for (int n = 0; n < NCH; n++) begin
      if (a[7:4] == 4'(n)) begin
        case (a[3:0])
          4'h0: r = m_load[n];
          4'h4: r = m_cur[n];
          4'h8: r = {29'd0, m_mask[n], m_mode[n], m_en[n]};
          4'hC: r = {31'd0, m_raw[n]};
          default: r = '0;
        endcase
      end
    end
    case (a)
      8'hF0, 8'hF4: r = ints;
      8'hF8:        r = raws;
`ifdef TIMER_BANK_PRESCALE_EN
      8'hFC:        r = {24'd0, m_ps};
`endif
      default: ;
    endcase
    return r;
  endfunction

  task automatic model_step();
    logic tick, wr, rd, cw, lw, eoi, expire;
    if (preset) begin
      for (int n = 0; n < NCH; n++) begin
        m_load[n] = '0; m_cur[n] = '0; m_en[n] = 1'b0; m_mode[n] = 1'b0;
        m_mask[n] = 1'b0; m_raw[n] = 1'b0; m_ten[n] = 1'b0; m_trig[n] = 1'b0;
      end
      m_ps = '0;
      m_pcnt = '0;
      return;
    end
    wr = psel && penable && pwrite;
    rd = psel && penable && !pwrite;
    tick = 1'b1;
`ifdef TIMER_BANK_PRESCALE_EN
    tick = (m_pcnt == m_ps);
    if (wr && paddr == 8'hFC) begin
      m_ps = pwdata[7:0];
      m_pcnt = '0;
    end else if (tick) m_pcnt = '0;
    else m_pcnt = m_pcnt + 8'd1;
`endif
    for (int n = 0; n < NCH; n++) begin
      cw  = wr && (paddr == 8'(n * 16 + 8));
      lw  = wr && (paddr == 8'(n * 16));
      eoi = rd && ((paddr == 8'(n * 16 + 12)) || (paddr == 8'hF4));
      expire = 1'b0;
      if (m_en[n]) begin
        if (cw && !pwdata[0]) m_en[n] = 1'b0;
        else if (tick) begin
          if (m_cur[n] == 0) begin
            expire = 1'b1;
            if (m_mode[n]) m_cur[n] = m_load[n];
            else m_en[n] = 1'b0;
          end else m_cur[n] = m_cur[n] - 1;
        end
      end else if (cw && pwdata[0]) begin
        m_en[n] = 1'b1;
        m_cur[n] = m_load[n];
      end
      m_trig[n] = expire && m_ten[n];
      if (expire) m_raw[n] = 1'b1;
      else if (eoi) m_raw[n] = 1'b0;
      if (etb_off[n]) m_ten[n] = 1'b0;
      else if (etb_on[n]) m_ten[n] = 1'b1;
      if (cw) begin
        m_mode[n] = pwdata[1];
        m_mask[n] = pwdata[2];
      end
      if (lw) m_load[n] = pwdata;
    end
  endtask

  initial forever begin
    @(posedge pclk);
    model_step();
  end

  initial forever begin
    logic [1:0] ei, et;
    @(posedge pclk);
    #1;
    for (int n = 0; n < NCH; n++) begin
      ei[n] = m_raw[n] & ~m_mask[n];
      et[n] = m_trig[n];
    end
    chk("model_intr", 32'(intr), 32'(ei));
    chk("model_etb_trig", 32'(etb_trig), 32'(et));
    chk("model_prdata", prdata, (psel && !pwrite) ? model_read(paddr) : 32'd0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic [31:0] d16);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    d = prdata;
    d16 = prdata16;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic count_trig(input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge pclk);
      #1;
      if (etb_trig[0]) cnt++;
    end
  endtask

  logic [31:0] exp_cur [5] = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd3};
  logic [31:0] rd, rd16;
  int          cnt;
  logic        found;

  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; etb_on = '0; etb_off = '0;
    repeat (3) @(negedge pclk);
    chk("rst_intr", 32'(intr), 32'd0);
    chk("rst_etb", 32'(etb_trig), 32'd0);
    chk("rst_intr16", 32'(intr16), 32'd0);
    chk("rst_etb16", 32'(etb16), 32'd0);
    preset = 1'b0;

    // Asynchronous reset in the middle of a count
    apb_write(8'h00, 32'd10);
    apb_write(8'h08, 32'd1);
    repeat (3) @(negedge pclk);
    psel = 1'b1; pwrite = 1'b0; paddr = 8'h04;
    #1;
    chk("midcount_curval", prdata, 32'd7);
    #2;
    preset = 1'b1;
    #1;
    chk("async_rst_curval", prdata, 32'd0);
    paddr = 8'h08;
    #1;
    chk("async_rst_ctrl", prdata, 32'd0);
    chk("async_rst_intr", 32'(intr), 32'd0);
    chk("async_rst_etb", 32'(etb_trig), 32'd0);
    repeat (2) @(negedge pclk);
    preset = 1'b0;
    psel = 1'b0;

    // Periodic, LOAD=3, with ETB trigger enabled on ch0
    @(negedge pclk);
    etb_on = 2'b01;
    @(negedge pclk);
    etb_on = 2'b00;
    apb_write(8'h00, 32'd3);
    apb_write(8'h08, 32'd3);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h04;
    cnt = 0;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) @(negedge pclk);
      #1;
      if (k <= 4) chk("periodic_curval", prdata, exp_cur[k]);
      if (k == 3) chk("periodic_intr_before", 32'(intr[0]), 32'd0);
      if (k == 4) chk("periodic_intr_after", 32'(intr[0]), 32'd1);
      if (k > 0 && etb_trig[0]) cnt++;
    end
    psel = 1'b0;
    chk("periodic_expiries_12cyc", 32'(cnt), 32'd3);

    // LOAD=2 picked up at the next reload; then trigger on+off together
    apb_write(8'h00, 32'd2);
    repeat (5) @(negedge pclk);
    count_trig(9, cnt);
    chk("etb_pulses_9cyc", 32'(cnt), 32'd3);
    @(negedge pclk);
    etb_on = 2'b01; etb_off = 2'b01;
    @(negedge pclk);
    etb_on = 2'b00; etb_off = 2'b00;
    @(negedge pclk);
    count_trig(12, cnt);
    chk("etb_on_off_no_pulse", 32'(cnt), 32'd0);

    // EOI read landing on the expiry cycle
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge pclk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h04;
      #1;
      if (prdata == 32'd1) found = 1'b1;
    end
    chk("race_found_curval1", 32'(found), 32'd1);
    paddr = 8'h0C;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    penable = 1'b0; paddr = 8'hF8;
    #1;
    chk("race_raw_kept", prdata & 32'd1, 32'd1);
    psel = 1'b0;
    apb_write(8'h08, 32'd0);
    apb_read(8'h0C, rd, rd16);
    chk("ch0_eoi_read", rd, 32'd1);

    // One-shot with mask on ch1
    apb_write(8'h10, 32'd5);
    apb_write(8'h18, 32'd5);
    repeat (10) @(negedge pclk);
    apb_read(8'hF8, rd, rd16);
    chk("oneshot_rawint", rd, 32'h2);
    apb_read(8'hF0, rd, rd16);
    chk("oneshot_intstat", rd, 32'h0);
    chk("oneshot_intr", 32'(intr), 32'd0);
    apb_read(8'h18, rd, rd16);
    chk("oneshot_ctrl", rd, 32'h4);
    apb_read(8'h14, rd, rd16);
    chk("oneshot_curval", rd, 32'd0);
    apb_read(8'h1C, rd, rd16);
    chk("oneshot_eoi", rd, 32'd1);
    apb_read(8'hF8, rd, rd16);
    chk("oneshot_raw_cleared", rd, 32'h0);

    // Width rule: write 0x12345 to LOAD of both instances
    apb_write(8'h00, 32'h0001_2345);
    apb_read(8'h00, rd, rd16);
    chk("load_w32", rd, 32'h0001_2345);
    chk("load_w16", rd16, 32'h0000_2345);
    apb_read(8'h40, rd, rd16);
    chk("unmapped_read", rd, 32'd0);

`ifdef TIMER_BANK_PRESCALE_EN
    apb_write(8'h00, 32'd1);
    apb_write(8'hFC, 32'd3);
    apb_write(8'h08, 32'd1);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h04;
    #1;
    chk("prescale_curval_j3", prdata, 32'd1);
    @(negedge pclk);
    #1;
    chk("prescale_curval_j4", prdata, 32'd0);
    paddr = 8'hF8;
    repeat (3) @(negedge pclk);
    #1;
    chk("prescale_raw_j7", prdata, 32'd0);
    @(negedge pclk);
    #1;
    chk("prescale_raw_j8", prdata, 32'd1);
    psel = 1'b0;
`endif

    repeat (2) @(negedge pclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
